// File: rtl/mult_share_arbiter.sv
// Two-requester round-robin front end around one iterative shift-add multiplier.
// Each operation takes WIDTH+2 cycles from grant to the next possible grant.
module mult_share_arbiter #(
    parameter int unsigned WIDTH = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               i_req_0,
    input  logic [WIDTH-1:0]   i_a_0,
    input  logic [WIDTH-1:0]   i_b_0,
    input  logic               i_req_1,
    input  logic [WIDTH-1:0]   i_a_1,
    input  logic [WIDTH-1:0]   i_b_1,
    output logic               o_gnt_0,
    output logic               o_gnt_1,
    output logic               o_done_0,
    output logic               o_done_1,
    output logic [2*WIDTH-1:0] o_product,
    output logic               o_owner,
    output logic               o_busy
);

    localparam int unsigned PW = 2 * WIDTH;
    localparam int unsigned CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic            last_q, last_d;
    logic            sel_q, sel_d;
    logic [PW-1:0]   acc_q, acc_d;
    logic [PW-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [PW-1:0]   product_q, product_d;
    logic            owner_q, owner_d;
    logic            gnt0_q, gnt0_d;
    logic            gnt1_q, gnt1_d;
    logic            done0_q, done0_d;
    logic            done1_q, done1_d;
    logic            busy_q, busy_d;
    logic            win_c;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            last_q    <= 1'b1;
            sel_q     <= 1'b0;
            acc_q     <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            cnt_q     <= '0;
            product_q <= '0;
            owner_q   <= 1'b0;
            gnt0_q    <= 1'b0;
            gnt1_q    <= 1'b0;
            done0_q   <= 1'b0;
            done1_q   <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            sel_q     <= sel_d;
            acc_q     <= acc_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
            owner_q   <= owner_d;
            gnt0_q    <= gnt0_d;
            gnt1_q    <= gnt1_d;
            done0_q   <= done0_d;
            done1_q   <= done1_d;
            busy_q    <= busy_d;
        end
    end

    // Arbitration, operand capture and shift-add iteration
    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        sel_d     = sel_q;
        acc_d     = acc_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        cnt_d     = cnt_q;
        product_d = product_q;
        owner_d   = owner_q;
        gnt0_d    = 1'b0;
        gnt1_d    = 1'b0;
        done0_d   = 1'b0;
        done1_d   = 1'b0;
        win_c     = 1'b0;

        case (state_q)
            IDLE: begin
                if (i_req_0 || i_req_1) begin
                    // On a tie the requester not served last wins
                    win_c    = (i_req_0 && i_req_1) ? ~last_q : i_req_1;
                    mcand_d  = win_c ? PW'(i_a_1) : PW'(i_a_0);
                    mplier_d = win_c ? i_b_1 : i_b_0;
                    acc_d    = '0;
                    cnt_d    = '0;
                    sel_d    = win_c;
                    last_d   = win_c;
                    gnt0_d   = ~win_c;
                    gnt1_d   = win_c;
                    state_d  = CALC;
                end
            end
            CALC: begin
                acc_d    = acc_q + (mplier_q[0] ? mcand_q : '0);
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == LAST_ITER) begin
                    product_d = acc_d;
                    owner_d   = sel_q;
                    done0_d   = ~sel_q;
                    done1_d   = sel_q;
                    state_d   = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    assign o_gnt_0   = gnt0_q;
    assign o_gnt_1   = gnt1_q;
    assign o_done_0  = done0_q;
    assign o_done_1  = done1_q;
    assign o_product = product_q;
    assign o_owner   = owner_q;
    assign o_busy    = busy_q;

endmodule

// File: doc/mult_share_arbiter.md
# mult_share_arbiter

Shares one iterative shift-add multiplier between two requesters with a round-robin grant and a req/gnt/done handshake. It sits between the input-sampling logic and the product/display path. It replaces per-requester multiplier instances with a single datapath that each requester uses in turn. Fixed latency per operation, with no starvation under continuous contention.

## Interface
- WIDTH, 4, operand width; product is 2*WIDTH bits; WIDTH >= 2

- clk  in  1  single clock; all state updates on rising edge
- reset  in  1  synchronous, active-high; one clock, synchronous active-high reset
- i_req_0  in  1  request from requester 0; held high until o_gnt_0 seen
- i_a_0  in  WIDTH  multiplicand, requester 0; stable while i_req_0 high
- i_b_0  in  WIDTH  multiplier, requester 0; stable while i_req_0 high
- i_req_1, i_a_1, i_b_1  in  1/WIDTH/WIDTH  same for requester 1
- o_gnt_0  out  1  one-cycle pulse: requester 0 operands captured
- o_gnt_1  out  1  same for requester 1
- o_done_0  out  1  one-cycle pulse: o_product valid for requester 0
- o_done_1  out  1  same for requester 1
- o_product  out  2*WIDTH  last completed product; held until next completion
- o_owner  out  1  requester index of o_product; updated with o_product
- o_busy  out  1  high whenever state != IDLE

## Operation
- States: IDLE, CALC, DONE.
- IDLE:
  - Samples i_req_0/1 each edge.
  - If any request is high: pick a winner, capture its operands into mcand (2*WIDTH, zero-extended) and mplier (WIDTH), clear acc and iteration counter, pulse the winner's o_gnt, go to CALC.
  - If no request is high: stay in IDLE.
- Arbitration:
  - A lone requester always wins.
  - If both requesters are high, the winner is the requester not granted most recently; the pointer `last` records it.
  - `last` updates on every grant.
  - After reset, requester 0 has priority on a tie.
- CALC, one iteration per edge, WIDTH iterations total:
  - If mplier[0] is 1: acc <= acc + mcand.
  - mcand <= mcand << 1; mplier <= mplier >> 1; counter++.
  - On the WIDTH-th iteration: o_product <= final acc value, including that iteration's add; o_owner <= the granted index; pulse the owner's o_done; go to DONE.
- DONE: one cycle, then go to IDLE. No grant is issued from DONE or CALC.
- Arithmetic:
  - Unsigned. acc is 2*WIDTH bits and never overflows (max (2^W-1)^2).
  - Zero operands take full latency; there is no early exit.
- Requests while busy stay pending. The controller ignores them until IDLE, and the requester must keep req high.
- A requester dropping req before its gnt withdraws the request; nothing is captured.
- Req still high on the edge after gnt is ignored, because the controller is not in IDLE. Req still high when the controller next reaches IDLE counts as a new request.
- Reset values:
  - state IDLE, last = 1 (so requester 0 wins the first tie).
  - acc, mcand, mplier, counter = 0.
  - o_product = 0, o_owner = 0, all gnt/done = 0, o_busy = 0.
- Reset mid-operation aborts: no o_done is issued for the aborted operation, o_product is cleared, and the pending requester must re-request.

## Timing
- Edge E0 (IDLE, req high): capture; o_gnt high in cycle E0–E1; o_busy high from E0.
- Edges E1..E_WIDTH: iterations.
- At E_WIDTH: o_product/o_owner update; o_done high in cycle E_WIDTH–E_WIDTH+1.
- E_WIDTH+1: return to IDLE; o_busy low.
- Earliest next grant: E_WIDTH+2.
- Period is WIDTH+2 cycles per operation; for WIDTH=4, done is 4 cycles after gnt and the period is 6.
- All outputs are registered; no combinational path from inputs to outputs.
- o_gnt_0/o_gnt_1 are never high together, and neither are o_done_0/o_done_1.

## Test plan
- Reset, then requester 0 alone with a=7, b=6:
  - o_gnt_0 pulses 1 cycle.
  - o_done_0 rises exactly 4 edges later with o_product=42, o_owner=0.
  - o_product holds 42 afterward.
- Both requesters high in the same cycle after reset (0: 15×15, 1: 3×5):
  - Requester 0 is served first with 225.
  - Requester 1 is granted at E6 and gets 15, o_owner=1.
  - Exactly 6 cycles separate the grants.
- Both requesters held continuously for 6 operations:
  - Grants alternate 0,1,0,1,0,1.
  - No requester is granted twice in a row.
- Zero and edge operands (0×13, 13×0, 1×1, 15×1):
  - Products 0, 0, 1, 15.
  - Latency identical to the nonzero cases.
- Reset asserted at the second CALC iteration of 9×9:
  - All outputs are 0 on the next cycle.
  - No o_done is issued.
  - After reset, a fresh 9×9 returns 81.
- Requester 1 raises req for one cycle while busy, then drops it before IDLE:
  - No grant and no done are issued for requester 1.
  - The in-flight requester-0 result is unaffected.
